// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between fetch control and the PC sequencer
interface pc_sequencer_if;
    logic [11:0] offset_in;
    logic        jump;
    logic        branch;
    logic        taken;
    logic        halt;
    logic        stall;
    logic [15:0] pc_out;
    logic        pc_valid;
    logic        flush;
    logic        halted;

    modport master (
        output offset_in, jump, branch, taken, halt, stall,
        input  pc_out, pc_valid, flush, halted
    );

    modport slave (
        input  offset_in, jump, branch, taken, halt, stall,
        output pc_out, pc_valid, flush, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with redirect flush bubbles and a sticky halt
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] jump_tgt, branch_tgt;

    assign jump_tgt   = pc_q + {{3{bus.offset_in[11]}}, bus.offset_in, 1'b0};
    assign branch_tgt = pc_q + {{7{bus.offset_in[7]}}, bus.offset_in[7:0], 1'b0};

    assign bus.pc_out   = pc_q;
    assign bus.pc_valid = state_q == RUN;
    assign bus.flush    = state_q == FLUSH;
    assign bus.halted   = state_q == HALT;

    // next-state, counter and PC selection; stall outranks every RUN request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: if (!bus.stall) begin
                if (bus.jump || (bus.branch && bus.taken)) begin
                    pc_d    = bus.jump ? jump_tgt : branch_tgt;
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (bus.halt) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 16'd2;
                end
            end
            FLUSH: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = cnt_q <= 3'd1 ? RUN : FLUSH;
            end
            HALT: ;
            default: state_d = RUN;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for the PC sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_VECTOR(16'h0000), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic        rn, j, b, t, hl, s;
        logic [11:0] off;
        logic [15:0] pc;
        logic        v, f, h;
    } row_t;

    typedef struct {
        logic [15:0] pc;
        logic        v, f, h;
    } exp_t;

    exp_t exp_q[$];
    row_t rows[$];
    int checks = 0;
    int failures = 0;

    function automatic row_t mk(input logic rn, j, b, t, hl, s, input logic [11:0] off,
                                input logic [15:0] pc, input logic v, f, h);
        row_t r;
        r.rn = rn; r.j = j; r.b = b; r.t = t; r.hl = hl; r.s = s; r.off = off;
        r.pc = pc; r.v = v; r.f = f; r.h = h;
        return r;
    endfunction

    task automatic drive(input row_t r);
        rst_n = r.rn;
        bus.jump = r.j;
        bus.branch = r.b;
        bus.taken = r.t;
        bus.halt = r.hl;
        bus.stall = r.s;
        bus.offset_in = r.off;
        exp_q.push_back('{r.pc, r.v, r.f, r.h});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0004,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0006,1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL reset[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    task automatic test_jump;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        for (int k = 1; k <= 8; k++)
            rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'(2 * k),1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'hFFE, 16'h000C,0,1,0));
        rows.push_back(mk(1,1,1,1,1,1,12'h100, 16'h000C,0,1,0));
        rows.push_back(mk(1,1,0,0,1,1,12'h100, 16'h000C,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h000E,1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL jump[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    task automatic test_branch;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'h080, 16'h0100,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0100,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0100,1,0,0));
        rows.push_back(mk(1,0,1,1,0,0,12'hF7F, 16'h01FE,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h01FE,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h01FE,1,0,0));
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'h080, 16'h0100,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0100,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0100,1,0,0));
        rows.push_back(mk(1,0,1,0,0,0,12'h07F, 16'h0102,1,0,0));
        rows.push_back(mk(1,0,1,1,0,0,12'h0FF, 16'h0100,0,1,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL branch[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'hFFF, 16'hFFFE,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'hFFFE,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'hFFFE,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'h800, 16'hF002,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'hF002,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'hF002,1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL wrap[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    task automatic test_stall;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,0,0,0,0,1,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,0,0,0,1,1,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,1,0,0,0,1,12'h010, 16'h0002,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'h010, 16'h0022,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0022,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0022,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0024,1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL stall[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    task automatic test_halt;
        exp_t e;
        rows = {};
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0002,1,0,0));
        rows.push_back(mk(1,0,0,0,1,0,12'h000, 16'h0002,0,0,1));
        for (int k = 0; k < 10; k++)
            rows.push_back(mk(1,1,k[0],1,k[1],k[2],12'h010, 16'h0002,0,0,1));
        rows.push_back(mk(0,0,0,0,0,0,12'h000, 16'h0000,1,0,0));
        rows.push_back(mk(1,1,0,0,1,0,12'h004, 16'h0008,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0008,0,1,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0008,1,0,0));
        rows.push_back(mk(1,1,0,0,0,0,12'h004, 16'h0010,0,1,0));
        rows.push_back(mk(0,1,0,0,1,0,12'h004, 16'h0000,1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,12'h000, 16'h0002,1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pc_out, bus.pc_valid, bus.flush, bus.halted} !== {e.pc, e.v, e.f, e.h}) begin
                failures++;
                $display("FAIL halt[%0d] got pc=%h v=%b f=%b h=%b want pc=%h v=%b f=%b h=%b",
                         i, bus.pc_out, bus.pc_valid, bus.flush, bus.halted, e.pc, e.v, e.f, e.h);
            end
        end
    endtask

    initial begin
        bus.jump = 1'b0;
        bus.branch = 1'b0;
        bus.taken = 1'b0;
        bus.halt = 1'b0;
        bus.stall = 1'b0;
        bus.offset_in = '0;
        #1;
        test_reset();
        test_jump();
        test_branch();
        test_wrap();
        test_stall();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, the number of bubble cycles issued after a taken redirect (legal range 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port offset_in  input  12  immediate; bits [11:0] are used for jump, bits [7:0] for branch.
REQ-006 SHALL have port jump  input  1  unconditional redirect request.
REQ-007 SHALL have port branch  input  1  conditional redirect request.
REQ-008 SHALL have port taken  input  1  branch condition result; qualifies branch only.
REQ-009 SHALL have port halt  input  1  request to stop fetching.
REQ-010 SHALL have port stall  input  1  downstream hold; freezes the PC in RUN.
REQ-011 SHALL have port pc_out  output  16  current fetch address.
REQ-012 SHALL have port pc_valid  output  1  pc_out is a valid fetch address this cycle.
REQ-013 SHALL have port flush  output  1  squash of in-flight instructions.
REQ-014 SHALL have port halted  output  1  block is in HALT.

Function
REQ-015 SHALL implement three states: RUN, FLUSH and HALT, with a 3-bit flush counter.
REQ-016 SHALL compute the jump target as pc_out + (sign-extend offset_in[11:0] to 16 bits, shifted left 1), modulo 2^16.
REQ-017 SHALL compute the branch target as pc_out + (sign-extend offset_in[7:0] to 16 bits, shifted left 1), modulo 2^16.
REQ-018 SHALL, in RUN, apply this priority each cycle: stall (hold PC, stay in RUN); jump (load jump target); branch&taken (load branch target); halt (enter HALT, hold PC); otherwise pc_out <= pc_out + 2, modulo 2^16.
REQ-019 SHALL treat branch with taken=0 as no request, so the PC increments by 2 and no flush occurs.
REQ-020 SHALL, on a taken redirect, load the target into pc_out on the same edge, enter FLUSH, and load the counter with FLUSH_CYCLES.
REQ-021 SHALL, in FLUSH, drive flush=1 and pc_valid=0, hold pc_out, and decrement the counter each cycle.
REQ-022 SHALL return to RUN on the edge at which the counter equals 1, so that flush is high for exactly FLUSH_CYCLES cycles.
REQ-023 SHALL, in FLUSH, ignore jump, branch, halt and stall; stall SHALL NOT extend FLUSH.
REQ-024 SHALL, in HALT, drive halted=1 and pc_valid=0, hold pc_out, and ignore all requests; the only exit is reset.
REQ-025 SHALL drive pc_valid=1 in RUN, including stalled cycles.
REQ-026 SHALL drive flush=0 outside FLUSH.
REQ-027 SHALL, when jump and halt are asserted together in RUN, take the jump and drop the halt.
REQ-028 SHALL register all outputs: they are decoded from registered state only, with no combinational path from inputs.

Reset
REQ-029 SHALL, on a rising edge with rst_n=0, set pc_out=RESET_VECTOR, state=RUN, counter=0, flush=0, halted=0 and pc_valid=1, regardless of the current state.
REQ-030 SHALL let reset override every other input, including reset asserted mid-FLUSH and reset asserted in HALT.

Verification
REQ-031 SHALL cover reset then three free-run cycles -> pc_out = 0x0000, 0x0002, 0x0004, 0x0006, with pc_valid=1 and flush=0 throughout.
REQ-032 SHALL cover pc=0x0010 with jump=1 and offset_in=12'hFFE -> pc_out=0x000C next cycle, then flush=1 and pc_valid=0 for 2 cycles, then pc_out=0x000E in RUN.
REQ-033 SHALL cover pc=0x0100 with branch=1, offset_in[7:0]=8'h7F, and taken=1 -> pc=0x01FE; the same case with taken=0 -> pc=0x0102 and no flush.
REQ-034 SHALL cover pc=0xFFFE free-running -> pc_out=0x0000 (wrap); also pc=0x0002 with jump, offset_in=12'h800 -> target 0xF002.
REQ-035 SHALL cover stall=1 together with jump=1 in RUN -> PC held and no flush; stall dropped next cycle with jump still high -> redirect occurs.
REQ-036 SHALL cover halt=1 -> halted=1, pc_valid=0, PC frozen for 10 cycles despite jump; then rst_n=0 for one cycle -> pc_out=RESET_VECTOR and halted=0; rst_n=0 in the 1st flush cycle -> RUN next cycle with flush=0.
